// File: rtl/adc_pkg.sv
// Shared types and helpers for the ADC pulse detector and its baseline tracker.
package adc_pkg;

    localparam int ADC_WIDTH      = 16;
    localparam int EVT_WIDTH_BITS = 8;
    localparam int EVT_TS_WIDTH   = 32;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        HOLDOFF,
        FAULT
    } det_state_t;

    typedef struct packed {
        logic [ADC_WIDTH-1:0]      peak;
        logic [EVT_WIDTH_BITS-1:0] width;
        logic [EVT_TS_WIDTH-1:0]   ts;
    } det_event_t;

    // Negative differences clamp to zero; the positive 17-bit range never exceeds 0xFFFF.
    function automatic logic [ADC_WIDTH-1:0] sat_peak(input logic signed [ADC_WIDTH:0] diff);
        return diff[ADC_WIDTH] ? '0 : diff[ADC_WIDTH-1:0];
    endfunction

    function automatic logic [EVT_WIDTH_BITS-1:0] sat_inc_width(input logic [EVT_WIDTH_BITS-1:0] w);
        return (w == '1) ? w : w + EVT_WIDTH_BITS'(1);
    endfunction

endpackage

// File: rtl/adc_baseline_tracker.sv
// IIR baseline: acc holds baseline scaled by 2^BASELINE_SHIFT; baseline = acc >>> BASELINE_SHIFT.
module adc_baseline_tracker
    import adc_pkg::*;
#(
    parameter int BASELINE_SHIFT = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        seed,
    input  logic                        update,
    input  logic                        freeze,
    input  logic signed [ADC_WIDTH-1:0] sample,
    output logic signed [ADC_WIDTH-1:0] baseline,
    output logic                        seeded
);

    localparam int ACC_W = ADC_WIDTH + BASELINE_SHIFT;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W:0]   sample_ext;
    logic signed [ACC_W:0]   baseline_ext;
    logic signed [ACC_W:0]   acc_ext;
    logic signed [ACC_W:0]   acc_next;

    assign baseline     = acc[ACC_W-1:BASELINE_SHIFT];
    assign sample_ext   = {{(ACC_W + 1 - ADC_WIDTH){sample[ADC_WIDTH-1]}}, sample};
    assign baseline_ext = {{(ACC_W + 1 - ADC_WIDTH){baseline[ADC_WIDTH-1]}}, baseline};
    assign acc_ext      = {acc[ACC_W-1], acc};
    // One guard bit is enough: acc + sample - baseline stays inside the ACC_W signed range.
    assign acc_next     = acc_ext + sample_ext - baseline_ext;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            seeded <= 1'b0;
        end else if (seed) begin
            acc    <= sample_ext[ACC_W-1:0] <<< BASELINE_SHIFT;
            seeded <= 1'b1;
        end else if (update && !freeze) begin
            acc    <= acc_next[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/adc_pulse_detector.sv
// Paces ADC conversions, captures samples, tracks a baseline and emits one event per threshold pulse.
module adc_pulse_detector
    import adc_pkg::*;
#(
    parameter int SAMPLE_PERIOD  = 128,
    parameter int BASELINE_SHIFT = 4,
    parameter int HOLDOFF        = 8,
    parameter int TS_WIDTH       = EVT_TS_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [ADC_WIDTH-1:0]      threshold,
    output logic                      start_acquisition,
    input  logic                      adc_data_enable,
    input  logic [ADC_WIDTH-1:0]      adc_data,
    input  logic                      adc_is_error,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [ADC_WIDTH-1:0]      evt_peak,
    output logic [EVT_WIDTH_BITS-1:0] evt_width,
    output logic [TS_WIDTH-1:0]       evt_timestamp,
    output logic [15:0]               drop_count,
    output logic                      error
);

    localparam int               CNT_W       = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(SAMPLE_PERIOD - 1);
    localparam int               HO_W        = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;

    det_state_t state;
    det_state_t state_next;

    logic [CNT_W-1:0]            period_cnt;
    logic                        outstanding;
    logic                        start_cond;
    logic                        adc_de_prev;
    logic                        sample_strobe;
    logic                        sample_vld;
    logic signed [ADC_WIDTH-1:0] sample_q;
    logic [TS_WIDTH-1:0]         sample_ts;
    logic [TS_WIDTH-1:0]         timestamp;

    logic signed [ADC_WIDTH-1:0] baseline;
    logic                        seeded;
    logic signed [ADC_WIDTH:0]   diff;
    logic                        detect;
    logic [ADC_WIDTH-1:0]        diff_sat;

    logic                        base_seed;
    logic                        base_update;
    logic                        pulse_start;
    logic                        pulse_extend;
    logic                        emit;
    logic                        holdoff_load;
    logic                        holdoff_step;

    logic [ADC_WIDTH-1:0]        pulse_peak;
    logic [EVT_WIDTH_BITS-1:0]   pulse_width;
    logic [TS_WIDTH-1:0]         pulse_ts;
    logic [HO_W-1:0]             holdoff_cnt;

    det_event_t                  evt_q;
    det_event_t                  evt_new;

    // Starts are held, not skipped, until the previous sample is in and the ADC is quiet.
    assign start_cond = enable && (period_cnt >= PERIOD_LAST) && !outstanding
                        && !adc_data_enable && !adc_is_error && (state != FAULT);

    always_ff @(posedge clk) begin
        if (reset) begin
            period_cnt        <= '0;
            outstanding       <= 1'b0;
            start_acquisition <= 1'b0;
        end else begin
            start_acquisition <= start_cond;
            if (start_cond) begin
                period_cnt <= '0;
            end else if (enable && (period_cnt < PERIOD_LAST)) begin
                period_cnt <= period_cnt + CNT_W'(1);
            end
            if (start_cond) begin
                outstanding <= 1'b1;
            end else if (sample_strobe) begin
                outstanding <= 1'b0;
            end
        end
    end

    assign sample_strobe = adc_data_enable && !adc_de_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            adc_de_prev <= 1'b0;
            sample_vld  <= 1'b0;
            sample_q    <= '0;
            sample_ts   <= '0;
            timestamp   <= '0;
        end else begin
            adc_de_prev <= adc_data_enable;
            sample_vld  <= sample_strobe;
            if (sample_strobe) begin
                sample_q  <= adc_data;
                sample_ts <= timestamp;
                timestamp <= timestamp + TS_WIDTH'(1);
            end
        end
    end

    adc_baseline_tracker #(
        .BASELINE_SHIFT(BASELINE_SHIFT)
    ) u_baseline (
        .clk      (clk),
        .reset    (reset),
        .seed     (base_seed),
        .update   (base_update),
        .freeze   (state != IDLE),
        .sample   (sample_q),
        .baseline (baseline),
        .seeded   (seeded)
    );

    // The seeding sample has no meaningful baseline, so it can never start a pulse.
    assign diff     = $signed({sample_q[ADC_WIDTH-1], sample_q}) - $signed({baseline[ADC_WIDTH-1], baseline});
    assign detect   = seeded && (diff > $signed({1'b0, threshold}));
    assign diff_sat = sat_peak(diff);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The module parameter HOLDOFF shadows the enum literal, hence the package-scoped name.
    always_comb begin
        state_next = state;
        if (adc_is_error) begin
            state_next = FAULT;
        end else if (sample_vld) begin
            case (state)
                IDLE:             if (detect) state_next = PULSE;
                PULSE:            if (!detect) state_next = (HOLDOFF == 0) ? IDLE : adc_pkg::HOLDOFF;
                adc_pkg::HOLDOFF: if (holdoff_cnt <= HO_W'(1)) state_next = IDLE;
                default:          state_next = state;
            endcase
        end
    end

    always_comb begin
        base_seed    = 1'b0;
        base_update  = 1'b0;
        pulse_start  = 1'b0;
        pulse_extend = 1'b0;
        emit         = 1'b0;
        holdoff_load = 1'b0;
        holdoff_step = 1'b0;
        if (sample_vld && !adc_is_error) begin
            case (state)
                IDLE: begin
                    if (!seeded) begin
                        base_seed = 1'b1;
                    end else if (detect) begin
                        pulse_start = 1'b1;
                    end else begin
                        base_update = 1'b1;
                    end
                end
                PULSE: begin
                    if (detect) begin
                        pulse_extend = 1'b1;
                    end else begin
                        emit         = 1'b1;
                        holdoff_load = 1'b1;
                    end
                end
                adc_pkg::HOLDOFF: holdoff_step = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_peak  <= '0;
            pulse_width <= '0;
            pulse_ts    <= '0;
            holdoff_cnt <= '0;
        end else begin
            if (pulse_start) begin
                pulse_peak  <= diff_sat;
                pulse_width <= EVT_WIDTH_BITS'(1);
                pulse_ts    <= sample_ts;
            end else if (pulse_extend) begin
                if (diff_sat > pulse_peak) pulse_peak <= diff_sat;
                pulse_width <= sat_inc_width(pulse_width);
            end
            if (holdoff_load) begin
                holdoff_cnt <= HO_W'(HOLDOFF);
            end else if (holdoff_step && (holdoff_cnt != '0)) begin
                holdoff_cnt <= holdoff_cnt - HO_W'(1);
            end
        end
    end

    always_comb begin
        evt_new       = '0;
        evt_new.peak  = pulse_peak;
        evt_new.width = pulse_width;
        evt_new.ts    = EVT_TS_WIDTH'(pulse_ts);
    end

    // A held event is never overwritten; an emit coinciding with a transfer refills the slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            evt_valid  <= 1'b0;
            evt_q      <= '0;
            drop_count <= '0;
        end else begin
            if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
            if (emit) begin
                if (!evt_valid || evt_ready) begin
                    evt_q     <= evt_new;
                    evt_valid <= 1'b1;
                end else if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
        end
    end

    assign evt_peak      = evt_q.peak;
    assign evt_width     = evt_q.width;
    assign evt_timestamp = TS_WIDTH'(evt_q.ts);
    assign error         = (state == FAULT);

endmodule

// File: tb/tb_adc_pulse_detector.sv
// Directed bench for adc_pulse_detector: the bench plays the ADC controller and checks events by hand-computed values.
module tb_adc_pulse_detector;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] threshold;
    logic        start_acquisition;
    logic        adc_data_enable;
    logic [15:0] adc_data;
    logic        adc_is_error;
    logic        evt_valid;
    logic        evt_ready;
    logic [15:0] evt_peak;
    logic [7:0]  evt_width;
    logic [31:0] evt_timestamp;
    logic [15:0] drop_count;
    logic        error;

    int     vectors = 0;
    int     miscompares = 0;
    int     sample_idx = 0;
    longint cyc = 0;
    int     start_count = 0;
    int     viol_count = 0;
    longint min_spacing = 1000000;
    longint last_start = 0;
    bit     have_last = 0;
    bit     pending = 0;

    always #5 clk = ~clk;

    adc_pulse_detector dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .threshold         (threshold),
        .start_acquisition (start_acquisition),
        .adc_data_enable   (adc_data_enable),
        .adc_data          (adc_data),
        .adc_is_error      (adc_is_error),
        .evt_valid         (evt_valid),
        .evt_ready         (evt_ready),
        .evt_peak          (evt_peak),
        .evt_width         (evt_width),
        .evt_timestamp     (evt_timestamp),
        .drop_count        (drop_count),
        .error             (error)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Records start spacing and starts issued while the ADC is busy or a sample is still owed.
    always @(negedge clk) begin
        if (reset) begin
            have_last   = 0;
            pending     = 0;
            start_count = 0;
            viol_count  = 0;
            min_spacing = 1000000;
        end else if (start_acquisition) begin
            if (adc_data_enable || pending) viol_count++;
            if (have_last && (cyc - last_start) < min_spacing) min_spacing = cyc - last_start;
            last_start = cyc;
            have_last  = 1;
            pending    = 1;
            start_count++;
        end else if (adc_data_enable) begin
            pending = 0;
        end
    end

    task automatic apply_reset();
        reset           = 1'b1;
        enable          = 1'b0;
        adc_data_enable = 1'b0;
        adc_data        = 16'h0000;
        adc_is_error    = 1'b0;
        evt_ready       = 1'b0;
        repeat (3) @(negedge clk);
        reset      = 1'b0;
        sample_idx = 0;
    endtask

    task automatic wait_for_start();
        int n = 0;
        while (!start_acquisition && n < 400) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (start_acquisition !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL start_timeout: start_acquisition=%b after %0d cycles, expected 1", start_acquisition, n);
        end
    endtask

    task automatic do_sample(input logic [15:0] value);
        wait_for_start();
        repeat (3) @(negedge clk);
        adc_data        = value;
        adc_data_enable = 1'b1;
        repeat (3) @(negedge clk);
        adc_data_enable = 1'b0;
        sample_idx++;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; threshold = 16'd0; adc_data_enable = 1'b0;
        adc_data = 16'h0; adc_is_error = 1'b0; evt_ready = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (start_acquisition !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_start: got %b want 0", start_acquisition); end
        vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b want 0", evt_valid); end
        vectors++; if (evt_peak !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_peak: got %h want 0", evt_peak); end
        vectors++; if (evt_width !== 8'h0) begin miscompares++; $display("[TB] FAIL reset_width: got %h want 0", evt_width); end
        vectors++; if (evt_timestamp !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_ts: got %h want 0", evt_timestamp); end
        vectors++; if (drop_count !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_drop: got %h want 0", drop_count); end
        vectors++; if (error !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_error: got %b want 0", error); end
        reset = 1'b0;
        repeat (300) @(negedge clk);
        vectors++; if (start_count !== 0) begin miscompares++; $display("[TB] FAIL disabled_starts: got %0d starts want 0", start_count); end
    endtask

    task automatic test_pacing();
        apply_reset();
        threshold = 16'd50;
        enable    = 1'b1;
        repeat (6) do_sample(16'h0100);
        repeat (4) @(negedge clk);
        vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL const_no_event: got %b want 0", evt_valid); end
        do_sample(16'h0133);
        do_sample(16'h0100);
        vectors++; if (evt_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL probe_valid: got %b want 1", evt_valid); end
        vectors++; if (evt_peak !== 16'd51) begin miscompares++; $display("[TB] FAIL probe_peak: got %0d want 51", evt_peak); end
        vectors++; if (evt_timestamp !== 32'd6) begin miscompares++; $display("[TB] FAIL probe_ts: got %0d want 6", evt_timestamp); end
        vectors++; if (min_spacing < 128) begin miscompares++; $display("[TB] FAIL start_spacing: got %0d want >=128", min_spacing); end
        vectors++; if (viol_count !== 0) begin miscompares++; $display("[TB] FAIL start_while_busy: got %0d want 0", viol_count); end
    endtask

    task automatic test_single_pulse();
        int ts_exp;
        apply_reset();
        threshold = 16'd150;
        enable    = 1'b1;
        do_sample(16'd100);
        do_sample(16'd100);
        ts_exp = sample_idx;
        do_sample(16'd400);
        do_sample(16'd900);
        do_sample(16'd300);
        vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_pulse_valid: got %b want 0", evt_valid); end
        wait_for_start();
        repeat (3) @(negedge clk);
        adc_data        = 16'd100;
        adc_data_enable = 1'b1;
        @(posedge clk); #1;
        vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL latency_early: got %b want 0", evt_valid); end
        @(posedge clk); #1;
        vectors++; if (evt_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL latency_2clk: got %b want 1", evt_valid); end
        repeat (2) @(negedge clk);
        adc_data_enable = 1'b0;
        sample_idx++;
        vectors++; if (evt_peak !== 16'd800) begin miscompares++; $display("[TB] FAIL pulse_peak: got %0d want 800", evt_peak); end
        vectors++; if (evt_width !== 8'd3) begin miscompares++; $display("[TB] FAIL pulse_width: got %0d want 3", evt_width); end
        vectors++; if (evt_timestamp !== 32'(ts_exp)) begin miscompares++; $display("[TB] FAIL pulse_ts: got %0d want %0d", evt_timestamp, ts_exp); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] holdoff_seq [8] = '{16'd100, 16'd100, 16'd100, 16'd600, 16'd100, 16'd100, 16'd100, 16'd100};
        int ts1;
        apply_reset();
        threshold = 16'd150;
        enable    = 1'b1;
        do_sample(16'd100);
        ts1 = sample_idx;
        do_sample(16'd400);
        do_sample(16'd100);
        vectors++; if (evt_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL first_event_valid: got %b want 1", evt_valid); end
        foreach (holdoff_seq[i]) do_sample(holdoff_seq[i]);
        do_sample(16'd100);
        do_sample(16'd600);
        do_sample(16'd100);
        vectors++; if (drop_count !== 16'd1) begin miscompares++; $display("[TB] FAIL drop_count: got %0d want 1", drop_count); end
        vectors++; if (evt_peak !== 16'd300) begin miscompares++; $display("[TB] FAIL held_peak: got %0d want 300", evt_peak); end
        vectors++; if (evt_width !== 8'd1) begin miscompares++; $display("[TB] FAIL held_width: got %0d want 1", evt_width); end
        vectors++; if (evt_timestamp !== 32'(ts1)) begin miscompares++; $display("[TB] FAIL held_ts: got %0d want %0d", evt_timestamp, ts1); end
        evt_ready = 1'b1;
        @(posedge clk); #1;
        vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL transfer_clears: got %b want 0", evt_valid); end
        evt_ready = 1'b0;
    endtask

    task automatic test_fault();
        int starts_before;
        apply_reset();
        threshold = 16'd150;
        enable    = 1'b1;
        do_sample(16'd100);
        do_sample(16'd100);
        do_sample(16'd900);
        @(negedge clk);
        adc_is_error = 1'b1;
        @(posedge clk); #1;
        vectors++; if (error !== 1'b1) begin miscompares++; $display("[TB] FAIL error_next_clk: got %b want 1", error); end
        starts_before = start_count;
        @(negedge clk);
        adc_data        = 16'd100;
        adc_data_enable = 1'b1;
        repeat (3) @(negedge clk);
        adc_data_enable = 1'b0;
        repeat (400) @(negedge clk);
        vectors++; if (start_count !== starts_before) begin miscompares++; $display("[TB] FAIL fault_starts: got %0d want %0d", start_count, starts_before); end
        vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL fault_no_event: got %b want 0", evt_valid); end
        reset        = 1'b1;
        adc_is_error = 1'b0;
        @(posedge clk); #1;
        vectors++; if (error !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_clears_error: got %b want 0", error); end
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_pulse();
        apply_reset();
        threshold = 16'd150;
        enable    = 1'b1;
        do_sample(16'd100);
        do_sample(16'd400);
        do_sample(16'd100);
        do_sample(16'd900);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_valid: got %b want 0", evt_valid); end
        vectors++; if (evt_peak !== 16'h0) begin miscompares++; $display("[TB] FAIL midreset_peak: got %h want 0", evt_peak); end
        vectors++; if (evt_timestamp !== 32'h0) begin miscompares++; $display("[TB] FAIL midreset_ts: got %h want 0", evt_timestamp); end
        reset      = 1'b0;
        sample_idx = 0;
        repeat (3) do_sample(16'd500);
        vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reseed_spurious: got %b want 0", evt_valid); end
        do_sample(16'd900);
        do_sample(16'd500);
        vectors++; if (evt_peak !== 16'd400) begin miscompares++; $display("[TB] FAIL reseed_peak: got %0d want 400", evt_peak); end
        vectors++; if (evt_timestamp !== 32'd3) begin miscompares++; $display("[TB] FAIL reseed_ts: got %0d want 3", evt_timestamp); end
    endtask

    task automatic test_saturation();
        apply_reset();
        threshold = 16'd0;
        enable    = 1'b1;
        do_sample(16'h8000);
        repeat (300) do_sample(16'h7FFF);
        do_sample(16'h8000);
        vectors++; if (evt_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL sat_valid: got %b want 1", evt_valid); end
        vectors++; if (evt_peak !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL sat_peak: got %h want ffff", evt_peak); end
        vectors++; if (evt_width !== 8'd255) begin miscompares++; $display("[TB] FAIL sat_width: got %0d want 255", evt_width); end
        vectors++; if (evt_timestamp !== 32'd1) begin miscompares++; $display("[TB] FAIL sat_ts: got %0d want 1", evt_timestamp); end
    endtask

    initial begin
        test_reset();
        test_pacing();
        test_single_pulse();
        test_back_to_back();
        test_fault();
        test_reset_mid_pulse();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
